// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : N-channel, WIDTH-bit valid/ready stream multiplexer with a
//               registered output stage. MODE=0 forwards the channel picked
//               by SEL; MODE=1 uses a fair round-robin arbiter over the
//               channels that currently offer a beat.
// Ports       :
//    CLK        clock, rising-edge
//    RST        synchronous active-high reset
//    IN_DATA    packed channel data, channel i at [i*WIDTH +: WIDTH]
//    IN_VALID   per-channel beat offer
//    IN_READY   per-channel accept strobe (one-hot or zero)
//    MODE       0 = manual select, 1 = round-robin
//    SEL        channel chosen in manual mode
//    OUT_DATA   registered output beat
//    OUT_VALID  OUT_DATA holds an unconsumed beat
//    OUT_READY  consumer accepts the beat
//    OUT_CH     source channel of the beat in OUT_DATA
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   localparam int SW       = $clog2(CHANNELS)
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [WIDTH*CHANNELS-1:0] IN_DATA,
   input  logic [CHANNELS-1:0]       IN_VALID,
   output logic [CHANNELS-1:0]       IN_READY,
   input  logic                      MODE,
   input  logic [SW-1:0]             SEL,
   output logic [WIDTH-1:0]          OUT_DATA,
   output logic                      OUT_VALID,
   input  logic                      OUT_READY,
   output logic [SW-1:0]             OUT_CH
);

   localparam logic [SW-1:0] c_LAST_RST = SW'(CHANNELS - 1);

   logic [WIDTH-1:0] r_out_data;
   logic [SW-1:0]    r_out_ch;
   logic             r_out_valid;
   logic [SW-1:0]    r_last;

   logic             w_load_en;
   logic             w_sel_ok;
   logic             w_rr_ok;
   logic [SW-1:0]    w_rr_cand;
   logic             w_cand_ok;
   logic [SW-1:0]    w_cand;
   logic [WIDTH-1:0] w_cand_data;

   // The output register can take a new beat when empty or being drained.
   assign w_load_en = !r_out_valid || OUT_READY;

   // Manual candidate. Comparing against every legal index means a SEL
   // beyond the last channel (non-power-of-2 CHANNELS) simply never matches.
   always_comb begin
      w_sel_ok = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (SEL == SW'(i)) begin
            w_sel_ok = IN_VALID[i];
         end
      end
   end

   // Round-robin candidate: scan from the channel after the last winner,
   // wrapping, so the last winner has lowest priority.
   always_comb begin
      w_rr_ok   = 1'b0;
      w_rr_cand = '0;
      for (int off = 1; off <= CHANNELS; off++) begin
         if (!w_rr_ok && IN_VALID[(int'(r_last) + off) % CHANNELS]) begin
            w_rr_ok   = 1'b1;
            w_rr_cand = SW'((int'(r_last) + off) % CHANNELS);
         end
      end
   end

   assign w_cand    = MODE ? w_rr_cand : SEL;
   assign w_cand_ok = MODE ? w_rr_ok   : w_sel_ok;

   // Data mux and grant decode; IN_DATA only reaches the output register.
   always_comb begin
      w_cand_data = '0;
      IN_READY    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_cand == SW'(i)) begin
            w_cand_data = IN_DATA[i*WIDTH +: WIDTH];
            IN_READY[i] = w_load_en && w_cand_ok && !RST;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
         r_last      <= c_LAST_RST;
      end else if (w_load_en) begin
         if (w_cand_ok) begin
            r_out_data  <= w_cand_data;
            r_out_ch    <= w_cand;
            r_out_valid <= 1'b1;
            // Tracked in manual mode too, so a switch to round-robin
            // continues fairly from the most recent winner.
            r_last      <= w_cand;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign OUT_DATA  = r_out_data;
   assign OUT_CH    = r_out_ch;
   assign OUT_VALID = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux_rr
// Description : Self-checking bench for stream_mux_rr (WIDTH=8, CHANNELS=4).
//               Directed scenarios followed by randomized producers and
//               consumer, all compared against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

   localparam int WIDTH = 8;
   localparam int CH    = 4;
   localparam int SW    = 2;

   logic                CLK = 1'b0;
   logic                RST;
   logic [WIDTH*CH-1:0] IN_DATA;
   logic [CH-1:0]       IN_VALID;
   logic [CH-1:0]       IN_READY;
   logic                MODE;
   logic [SW-1:0]       SEL;
   logic [WIDTH-1:0]    OUT_DATA;
   logic                OUT_VALID;
   logic                OUT_READY;
   logic [SW-1:0]       OUT_CH;

   stream_mux_rr #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_DATA   (IN_DATA),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .MODE      (MODE),
      .SEL       (SEL),
      .OUT_DATA  (OUT_DATA),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_CH    (OUT_CH)
   );

   always #5 CLK = ~CLK;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: contents of the output register, last winner, and
   // the channel granted in the most recent cycle (-1 for none).
   bit               m_known = 1'b0;
   bit               m_valid;
   logic [WIDTH-1:0] m_data;
   logic [SW-1:0]    m_ch;
   int               m_last;
   int               m_gnt = -1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Which channel the rules pick right now, -1 if none.
   function automatic int pick();
      if (!MODE) return IN_VALID[SEL] ? int'(SEL) : -1;
      for (int k = 1; k <= CH; k++) begin
         if (IN_VALID[(m_last + k) % CH]) return (m_last + k) % CH;
      end
      return -1;
   endfunction

   // One clock cycle: check at the falling edge, advance the model at the
   // rising edge, return #1 later so callers can drive new inputs.
   task automatic step();
      int            g;
      bit            load;
      logic [CH-1:0] exp_rdy;
      @(negedge CLK);
      load    = !m_valid || OUT_READY;
      g       = pick();
      exp_rdy = '0;
      if (!RST && load && g >= 0) exp_rdy[g] = 1'b1;
      check("in_ready", 32'(IN_READY), 32'(exp_rdy));
      if (m_known) begin
         check("out_valid", 32'(OUT_VALID), 32'(m_valid));
         check("out_data",  32'(OUT_DATA),  32'(m_data));
         check("out_ch",    32'(OUT_CH),    32'(m_ch));
      end
      @(posedge CLK);
      m_gnt = -1;
      if (RST) begin
         m_known = 1'b1;
         m_valid = 1'b0;
         m_data  = '0;
         m_ch    = '0;
         m_last  = CH - 1;
      end else if (load) begin
         if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = IN_DATA[g*WIDTH +: WIDTH];
            m_ch    = SW'(g);
            m_last  = g;
            m_gnt   = g;
         end else begin
            m_valid = 1'b0;
         end
      end
      #1;
   endtask

   initial begin
      // Reset with every channel offering a beat.
      RST       = 1'b1;
      IN_DATA   = 32'h0302_0100;
      IN_VALID  = 4'b1111;
      MODE      = 1'b0;
      SEL       = '0;
      OUT_READY = 1'b1;
      step();
      step();
      check("rst_valid", 32'(OUT_VALID), 32'd0);
      check("rst_data",  32'(OUT_DATA),  32'h00);
      check("rst_ch",    32'(OUT_CH),    32'd0);
      RST = 1'b0;

      // Manual selection walks 0..3, each beat one cycle after its SEL.
      for (int s = 0; s < CH; s++) begin
         SEL = SW'(s);
         step();
         check("man_data", 32'(OUT_DATA), 32'(s));
         check("man_ch",   32'(OUT_CH),   32'(s));
      end

      // Round-robin with all channels valid rotates 0,1,2,3,...
      MODE = 1'b1;
      for (int k = 0; k < 2*CH; k++) begin
         step();
         check("rr_ch", 32'(OUT_CH), 32'(k % CH));
      end

      // Only channels 1 and 3 valid.
      IN_VALID = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         step();
         check("rr_sparse_ch", 32'(OUT_CH), (k % 2 == 0) ? 32'd1 : 32'd3);
      end

      // Backpressure: first beat after reset held for three cycles.
      RST = 1'b1;
      step();
      RST      = 1'b0;
      IN_VALID = 4'b1111;
      step();
      check("bp_first", 32'(OUT_DATA), 32'h00);
      OUT_READY = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("bp_hold_data",  32'(OUT_DATA),  32'h00);
         check("bp_hold_valid", 32'(OUT_VALID), 32'd1);
      end
      OUT_READY = 1'b1;
      step();
      check("bp_next", 32'(OUT_DATA), 32'h01);

      // Manual select of an idle channel drains the output, then loads it.
      MODE     = 1'b0;
      SEL      = 2'd2;
      IN_VALID = 4'b1011;
      step();
      check("idle_valid", 32'(OUT_VALID), 32'd0);
      IN_VALID = 4'b1111;
      step();
      check("idle_then_data", 32'(OUT_DATA), 32'h02);
      check("idle_then_ch",   32'(OUT_CH),   32'd2);

      // Randomized producers that hold their beat until granted.
      for (int n = 0; n < 600; n++) begin
         RST       = ($urandom_range(0, 79) == 0);
         OUT_READY = 1'($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) MODE = ~MODE;
         if ($urandom_range(0, 3) == 0)  SEL  = SW'($urandom_range(0, CH-1));
         step();
         for (int i = 0; i < CH; i++) begin
            if (m_gnt == i || !IN_VALID[i]) begin
               IN_DATA[i*WIDTH +: WIDTH] = 8'($urandom);
               IN_VALID[i]               = 1'($urandom_range(0, 1));
            end
         end
      end
      RST = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
